aipp_t_noc_deflect_router: RTL and testbench

- Next-generation thermal-deflection NoC router.
- Generalised to N ports, with per-input buffering, round-robin output arbitration, multi-hop deflection search and a registered thermal-quiesce handshake.
- Sits between tile NIs and mesh links. Steers traffic away from thermally inhibited output ports without dropping flits.
- Per-flit deflection flag and a saturating deflection counter support telemetry.

---
 rtl/aipp_t_noc_pkg.sv | 59 +++++
 rtl/aipp_t_noc_fifo.sv | 55 +++++
 rtl/aipp_t_noc_deflect_router.sv | 165 ++++++++++++++++
 tb/tb_aipp_t_noc_deflect_router.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aipp_t_noc_pkg.sv
// Shared definitions for the thermal-deflection NoC router family:
// sizing helper, flit field layout and the deflection search used by
// routers and models alike.
package aipp_t_noc_pkg;

  // Largest port count the deflection search supports.
  localparam int MAX_PORTS = 32;
  localparam int TGT_W     = 5;

  // Flit layout inside a FIFO word: {dest, data}, data at bit 0.
  localparam int FLIT_DATA_LSB = 0;

  function automatic int flit_dest_lsb(input int data_width);
    return FLIT_DATA_LSB + data_width;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Result of resolving one head flit against the inhibit mask.
  typedef struct packed {
    logic             found;
    logic             deflected;
    logic [TGT_W-1:0] target;
  } route_t;

  // First non-inhibited output at or after dest, walking upwards and
  // wrapping. found=0 when every output is inhibited.
  function automatic route_t deflect_search(input logic [MAX_PORTS-1:0] inhibit,
                                            input logic [TGT_W-1:0]     dest,
                                            input int unsigned          num_ports);
    route_t      r;
    int unsigned idx;
    r   = '0;
    idx = 0;
    if (!inhibit[dest]) begin
      r.found  = 1'b1;
      r.target = dest;
    end else begin
      for (int unsigned k = 1; k < MAX_PORTS; k++) begin
        if (!r.found && (k < num_ports)) begin
          idx = 32'(dest) + k;
          if (idx >= num_ports) idx = idx - num_ports;
          if (!inhibit[idx[TGT_W-1:0]]) begin
            r.found     = 1'b1;
            r.deflected = 1'b1;
            r.target    = idx[TGT_W-1:0];
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aipp_t_noc_fifo.sv
// Synchronous FIFO holding one input's flits; registered occupancy count.
module aipp_t_noc_fifo
  import aipp_t_noc_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy update; simultaneous push and pop cancel out.
  // NOTE: state registers use non-blocking assignment so every always_ff reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write.
  // NOTE: the array has no reset; its contents are only visible through count-qualified pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/aipp_t_noc_deflect_router.sv
// N-port thermal-deflection router: per-input FIFO, deflection search on
// each head, per-output round-robin arbiter with an output register, a
// registered quiesce acknowledge and a saturating deflection counter.
module aipp_t_noc_deflect_router
  import aipp_t_noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  localparam int DEST_W    = clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            thermal_inhibit,
  output logic [NUM_PORTS-1:0]            thermal_ack,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS*DEST_W-1:0]     in_dest,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [NUM_PORTS-1:0]            out_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]            out_deflected,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic [CNT_W-1:0]                deflect_cnt
);

  localparam int FW     = DATA_WIDTH + DEST_W;
  localparam int DST_LO = flit_dest_lsb(DATA_WIDTH);
  localparam int FCW    = clog2(FIFO_DEPTH) + 1;

  logic [MAX_PORTS-1:0]           inhibit_ext;
  logic [FW-1:0]                  head [NUM_PORTS];
  route_t                         route [NUM_PORTS];
  logic [NUM_PORTS-1:0]           head_ok;
  logic [NUM_PORTS-1:0]           fifo_full;
  logic [NUM_PORTS-1:0]           fifo_empty;
  logic [NUM_PORTS-1:0]           pop;
  logic [NUM_PORTS*NUM_PORTS-1:0] gnt_flat;
  logic [NUM_PORTS-1:0]           defl_grant;
  logic [CNT_W-1:0]               cnt_q;
  logic [CNT_W:0]                 cnt_sum;

  assign inhibit_ext = MAX_PORTS'(thermal_inhibit);
  assign deflect_cnt = cnt_q;

  // Input side: one FIFO per port and target resolution of its head.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    logic [FCW-1:0] fifo_count;

    aipp_t_noc_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_valid[p] && !fifo_full[p] && !rst),
      .wr_data ({in_dest[p*DEST_W +: DEST_W], in_data[p*DATA_WIDTH +: DATA_WIDTH]}),
      .pop     (pop[p]),
      .rd_data (head[p]),
      .full    (fifo_full[p]),
      .empty   (fifo_empty[p]),
      .count   (fifo_count)
    );

    // Held low through reset so nothing is accepted while the FIFO clears.
    assign in_ready[p] = !rst && (fifo_count < FCW'(FIFO_DEPTH));

    // Out-of-range destinations fold back into the port range.
    assign route[p] = deflect_search(inhibit_ext,
                                     TGT_W'(32'(head[p][DST_LO +: DEST_W]) % NUM_PORTS),
                                     NUM_PORTS);
    assign head_ok[p] = !fifo_empty[p] && route[p].found;
  end

  // Output side: round-robin arbiter and output register per port.
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic [NUM_PORTS-1:0]  req;
    logic [NUM_PORTS-1:0]  gnt;
    logic                  any_gnt;
    logic [DEST_W-1:0]     rr_next;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  gnt_defl;
    logic                  can_load;
    logic [DEST_W-1:0]     rr_q;
    logic                  valid_q;
    logic                  defl_q;
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] data_q;

    assign can_load = !valid_q || out_ready[o];

    // Pick the first requesting input at or after rr_q; never grant an inhibited output.
    always_comb begin
      int idx;
      // NOTE: every combinational output gets a default first so no path infers a latch.
      req      = '0;
      gnt      = '0;
      any_gnt  = 1'b0;
      rr_next  = rr_q;
      gnt_data = '0;
      gnt_defl = 1'b0;
      idx      = 0;
      for (int p = 0; p < NUM_PORTS; p++)
        req[p] = head_ok[p] && (route[p].target == TGT_W'(o));
      if (can_load && !thermal_inhibit[o]) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          idx = int'(rr_q) + i;
          if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
          if (!any_gnt && req[idx]) begin
            any_gnt  = 1'b1;
            gnt[idx] = 1'b1;
            gnt_data = head[idx][DATA_WIDTH-1:0];
            gnt_defl = route[idx].deflected;
            rr_next  = (idx == NUM_PORTS - 1) ? '0 : DEST_W'(idx + 1);
          end
        end
      end
    end

    // Output register, pointer advance and quiesce acknowledge.
    always_ff @(posedge clk) begin
      if (rst) begin
        rr_q    <= '0;
        valid_q <= 1'b0;
        data_q  <= '0;
        defl_q  <= 1'b0;
        ack_q   <= 1'b0;
      end else begin
        if (any_gnt) begin
          valid_q <= 1'b1;
          data_q  <= gnt_data;
          defl_q  <= gnt_defl;
          rr_q    <= rr_next;
        end else if (out_ready[o]) begin
          valid_q <= 1'b0;
        end
        ack_q <= thermal_inhibit[o] && (!valid_q || out_ready[o]);
      end
    end

    assign gnt_flat[o*NUM_PORTS +: NUM_PORTS]   = gnt;
    assign defl_grant[o]                        = any_gnt && gnt_defl;
    assign out_valid[o]                         = valid_q;
    assign out_deflected[o]                     = defl_q;
    assign thermal_ack[o]                       = ack_q;
    assign out_data[o*DATA_WIDTH +: DATA_WIDTH] = data_q;
  end

  // An input is popped when any output granted it (at most one can).
  always_comb begin
    pop = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      for (int p = 0; p < NUM_PORTS; p++)
        if (gnt_flat[o*NUM_PORTS + p]) pop[p] = 1'b1;
  end

  // Saturating sum of deflected grants; the extra bit catches the overflow.
  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'($countones(defl_grant));

  // Deflection counter.
  always_ff @(posedge clk) begin
    if (rst)               cnt_q <= '0;
    else if (cnt_sum[CNT_W]) cnt_q <= '1;
    else                   cnt_q <= cnt_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_aipp_t_noc_deflect_router.sv
// Directed bench for the thermal-deflection router (4 ports, 32-bit data).
module tb_aipp_t_noc_deflect_router;

  localparam int DW = 32;
  localparam int NP = 4;
  localparam int DSW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   thermal_inhibit;
  logic [NP-1:0]   thermal_ack;
  logic [NP-1:0]   in_valid;
  logic [NP*DW-1:0] in_data;
  logic [NP*DSW-1:0] in_dest;
  logic [NP-1:0]   in_ready;
  logic [NP-1:0]   out_valid;
  logic [NP*DW-1:0] out_data;
  logic [NP-1:0]   out_deflected;
  logic [NP-1:0]   out_ready;
  logic [15:0]     deflect_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  aipp_t_noc_deflect_router #(
    .DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(4), .CNT_W(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .thermal_inhibit (thermal_inhibit),
    .thermal_ack     (thermal_ack),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_dest         (in_dest),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_deflected   (out_deflected),
    .out_ready       (out_ready),
    .deflect_cnt     (deflect_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [DW-1:0] d, input logic [DSW-1:0] dst);
    in_data[p*DW +: DW]    = d;
    in_dest[p*DSW +: DSW]  = dst;
    in_valid[p]            = 1'b1;
  endtask

  task automatic clear_in();
    in_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    thermal_inhibit = '0;
    in_valid = '0;
    in_data = '0;
    in_dest = '0;
    out_ready = '1;
    tick();
    tick();
    tests_run++;
    if (out_valid !== 4'h0) begin tests_failed++; $display("FAIL reset_out_valid: got %h want 0", out_valid); end
    tests_run++;
    if (out_data !== '0 || out_deflected !== 4'h0) begin tests_failed++; $display("FAIL reset_out_data: got %h/%h want 0", out_data, out_deflected); end
    tests_run++;
    if (thermal_ack !== 4'h0 || deflect_cnt !== 16'h0) begin tests_failed++; $display("FAIL reset_ack_cnt: got %h/%h want 0", thermal_ack, deflect_cnt); end
    tests_run++;
    if (in_ready !== 4'h0) begin tests_failed++; $display("FAIL reset_in_ready_low: got %h want 0", in_ready); end
    rst = 1'b0;
    tick();
    tests_run++;
    if (in_ready !== 4'hF) begin tests_failed++; $display("FAIL reset_in_ready_high: got %h want f", in_ready); end
  endtask

  task automatic test_basic_route();
    send(0, 32'hDEADBEEF, 2'd2);
    tick();
    clear_in();
    tests_run++;
    if (out_valid !== 4'h0) begin tests_failed++; $display("FAIL basic_early: got %h want 0", out_valid); end
    tick();
    tests_run++;
    if (out_valid !== 4'b0100) begin tests_failed++; $display("FAIL basic_valid: got %h want 4", out_valid); end
    tests_run++;
    if (out_data[2*DW +: DW] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL basic_data: got %h want deadbeef", out_data[2*DW +: DW]); end
    tests_run++;
    if (out_deflected[2] !== 1'b0 || deflect_cnt !== 16'd0) begin tests_failed++; $display("FAIL basic_defl: got %b/%0d want 0/0", out_deflected[2], deflect_cnt); end
    tick();
    tests_run++;
    if (out_valid !== 4'h0) begin tests_failed++; $display("FAIL basic_drop: got %h want 0", out_valid); end
  endtask

  task automatic test_deflect();
    thermal_inhibit = 4'b1100;
    send(0, 32'hCAFEBABE, 2'd2);
    tick();
    clear_in();
    tick();
    tests_run++;
    if (out_valid !== 4'b0001) begin tests_failed++; $display("FAIL deflect_valid: got %h want 1", out_valid); end
    tests_run++;
    if (out_data[0 +: DW] !== 32'hCAFEBABE) begin tests_failed++; $display("FAIL deflect_data: got %h want cafebabe", out_data[0 +: DW]); end
    tests_run++;
    if (out_deflected[0] !== 1'b1 || deflect_cnt !== 16'd1) begin tests_failed++; $display("FAIL deflect_flag_cnt: got %b/%0d want 1/1", out_deflected[0], deflect_cnt); end
    tests_run++;
    if (thermal_ack !== 4'b1100) begin tests_failed++; $display("FAIL deflect_ack: got %b want 1100", thermal_ack); end
    thermal_inhibit = '0;
    tick();
    tests_run++;
    if (thermal_ack !== 4'b0000 || out_valid !== 4'h0) begin tests_failed++; $display("FAIL deflect_ack_clear: got %b/%h want 0/0", thermal_ack, out_valid); end
  endtask

  task automatic test_contention();
    // Round 0 starts from rr_ptr[1]=0; rounds 1 and 2 are preceded by one
    // priming flit that moves the pointer, so the first grant rotates.
    int prime [3] = '{-1, 1, 0};
    int order [3][3] = '{'{0, 1, 3}, '{3, 0, 1}, '{1, 3, 0}};
    logic [DW-1:0] exp;
    for (int r = 0; r < 3; r++) begin
      if (prime[r] >= 0) begin
        exp = 32'h5000_0000 | DW'(r << 8) | DW'(prime[r]);
        send(prime[r], exp, 2'd1);
        tick();
        clear_in();
        tick();
        tests_run++;
        if (out_valid[1] !== 1'b1 || out_data[DW +: DW] !== exp) begin
          tests_failed++; $display("FAIL contention_prime r%0d: got %b/%h want 1/%h", r, out_valid[1], out_data[DW +: DW], exp);
        end
      end
      send(0, 32'hA000_0000 | DW'(r << 8) | 32'd0, 2'd1);
      send(1, 32'hA000_0000 | DW'(r << 8) | 32'd1, 2'd1);
      send(3, 32'hA000_0000 | DW'(r << 8) | 32'd3, 2'd1);
      tick();
      clear_in();
      for (int i = 0; i < 3; i++) begin
        tick();
        exp = 32'hA000_0000 | DW'(r << 8) | DW'(order[r][i]);
        tests_run++;
        if (out_valid[1] !== 1'b1 || out_data[DW +: DW] !== exp) begin
          tests_failed++; $display("FAIL contention r%0d slot%0d: got %b/%h want 1/%h", r, i, out_valid[1], out_data[DW +: DW], exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int accepted = 0;
    int nrx = 0;
    logic acc;
    logic [DW-1:0] rx [6];
    out_ready = 4'b1011;
    for (int c = 0; c < 8; c++) begin
      if (k < 6) send(0, 32'hB000_0000 + DW'(k), 2'd2); else clear_in();
      acc = in_valid[0] && in_ready[0];
      tick();
      if (acc) begin k++; accepted++; end
    end
    tests_run++;
    if (accepted !== 5 || in_ready[0] !== 1'b0) begin tests_failed++; $display("FAIL bp_accept: got %0d/%b want 5/0", accepted, in_ready[0]); end
    tests_run++;
    if (out_valid[2] !== 1'b1 || out_data[2*DW +: DW] !== 32'hB000_0000) begin tests_failed++; $display("FAIL bp_hold: got %b/%h want 1/b0000000", out_valid[2], out_data[2*DW +: DW]); end
    out_ready = 4'hF;
    for (int c = 0; c < 20; c++) begin
      if (out_valid[2] && nrx < 6) begin rx[nrx] = out_data[2*DW +: DW]; nrx++; end
      if (k < 6) send(0, 32'hB000_0000 + DW'(k), 2'd2); else clear_in();
      acc = in_valid[0] && in_ready[0];
      tick();
      if (acc) k++;
    end
    clear_in();
    tests_run++;
    if (nrx !== 6) begin tests_failed++; $display("FAIL bp_count: got %0d want 6", nrx); end
    for (int i = 0; i < nrx; i++) begin
      tests_run++;
      if (rx[i] !== 32'hB000_0000 + DW'(i)) begin tests_failed++; $display("FAIL bp_order %0d: got %h want %h", i, rx[i], 32'hB000_0000 + DW'(i)); end
    end
  endtask

  task automatic test_quiesce();
    out_ready = 4'b0111;
    send(1, 32'h5151_0003, 2'd3);
    tick();
    clear_in();
    tick();
    tests_run++;
    if (out_valid[3] !== 1'b1) begin tests_failed++; $display("FAIL quiesce_load: got %b want 1", out_valid[3]); end
    thermal_inhibit = 4'b1000;
    tick();
    tests_run++;
    if (thermal_ack[3] !== 1'b0 || out_valid[3] !== 1'b1) begin tests_failed++; $display("FAIL quiesce_stall1: got %b/%b want 0/1", thermal_ack[3], out_valid[3]); end
    tick();
    tests_run++;
    if (thermal_ack[3] !== 1'b0 || out_data[3*DW +: DW] !== 32'h5151_0003) begin tests_failed++; $display("FAIL quiesce_stall2: got %b/%h want 0/51510003", thermal_ack[3], out_data[3*DW +: DW]); end
    out_ready = 4'hF;
    tick();
    tests_run++;
    if (thermal_ack[3] !== 1'b1 || out_valid[3] !== 1'b0) begin tests_failed++; $display("FAIL quiesce_ack: got %b/%b want 1/0", thermal_ack[3], out_valid[3]); end
    thermal_inhibit = '0;
    tick();
    tests_run++;
    if (thermal_ack[3] !== 1'b0) begin tests_failed++; $display("FAIL quiesce_release: got %b want 0", thermal_ack[3]); end
  endtask

  task automatic test_all_inhibit_reset();
    thermal_inhibit = 4'hF;
    send(0, 32'h7777_0001, 2'd1);
    tick();
    clear_in();
    tick();
    tick();
    tick();
    tests_run++;
    if (out_valid !== 4'h0 || in_ready !== 4'hF) begin tests_failed++; $display("FAIL allinh_hold: got %h/%h want 0/f", out_valid, in_ready); end
    tests_run++;
    if (thermal_ack !== 4'hF || deflect_cnt !== 16'd1) begin tests_failed++; $display("FAIL allinh_ack_cnt: got %h/%0d want f/1", thermal_ack, deflect_cnt); end
    rst = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 4'h0 || thermal_ack !== 4'h0 || deflect_cnt !== 16'd0 || in_ready !== 4'h0) begin
      tests_failed++; $display("FAIL midreset: got v%h a%h c%0d r%h want 0/0/0/0", out_valid, thermal_ack, deflect_cnt, in_ready);
    end
    rst = 1'b0;
    thermal_inhibit = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (out_valid !== 4'h0) begin tests_failed++; $display("FAIL flush cycle%0d: got %h want 0", c, out_valid); end
    end
  endtask

  task automatic test_saturate();
    thermal_inhibit = 4'b1010;
    send(0, 32'h0000_5A00, 2'd1);
    send(1, 32'h0000_5A01, 2'd3);
    for (int n = 0; n < 101; n++) tick();
    tests_run++;
    if (deflect_cnt !== 16'd200) begin tests_failed++; $display("FAIL sat_rate: got %0d want 200", deflect_cnt); end
    tests_run++;
    if (out_valid !== 4'b0101 || out_deflected !== 4'b0101) begin tests_failed++; $display("FAIL sat_outputs: got %b/%b want 0101/0101", out_valid, out_deflected); end
    for (int n = 101; n < 32800; n++) tick();
    tests_run++;
    if (deflect_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_reach: got %h want ffff", deflect_cnt); end
    for (int n = 0; n < 5; n++) tick();
    tests_run++;
    if (deflect_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold: got %h want ffff", deflect_cnt); end
    clear_in();
    thermal_inhibit = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_route();
    test_deflect();
    test_contention();
    test_backpressure();
    test_quiesce();
    test_all_inhibit_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
